// File: rtl/operand_stage.sv
// operand_stage
//   Register-read / operand-select stage sitting between decode and the ALU.
//   Holds the architectural register file (x0 hard-wired to zero, one write
//   port, two combinational read ports with same-cycle writeback bypass) and
//   a single-entry output register carrying the ALU request.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   in_valid / in_ready          decode handshake
//   in_alu_op, in_rs1, in_rs2,
//   in_rd, in_use_imm, in_imm    decoded instruction fields
//   wb_en, wb_rd, wb_data        writeback write port
//   flush                        discard the held request, accept nothing
//   out_valid / out_ready        execute handshake
//   out_opcode, out_num1,
//   out_num2, out_rd             registered ALU request
module operand_stage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_alu_op,
    input  logic [4:0]      in_rs1,
    input  logic [4:0]      in_rs2,
    input  logic [4:0]      in_rd,
    input  logic            in_use_imm,
    input  logic [XLEN-1:0] in_imm,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      out_opcode,
    output logic [XLEN-1:0] out_num1,
    output logic [XLEN-1:0] out_num2,
    output logic [4:0]      out_rd
);

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [XLEN-1:0] rf_q [NREGS];
    logic [XLEN-1:0] rf_d [NREGS];

    // A write is live only for a non-zero, in-range destination.
    logic wb_live;
    assign wb_live = wb_en && (wb_rd != 5'd0) && (32'(wb_rd) < NREGS);

    always_comb begin
        rf_d = rf_q;
        if (wb_live) begin
            rf_d[wb_rd] = wb_data;
        end
    end

    // Combinational read with writeback bypass; x0 and out-of-range read 0.
    function automatic logic [XLEN-1:0] rf_read(input logic [4:0] idx);
        logic [XLEN-1:0] val;
        val = '0;
        if (idx != 5'd0 && 32'(idx) < NREGS) begin
            if (wb_live && wb_rd == idx) val = wb_data;
            else                         val = rf_q[idx];
        end
        return val;
    endfunction

    logic [XLEN-1:0] rd1_val, rd2_val;
    assign rd1_val = rf_read(in_rs1);
    assign rd2_val = rf_read(in_rs2);

    // ------------------------------------------------------------------
    // Output entry
    // ------------------------------------------------------------------
    logic            out_valid_q, out_valid_d;
    logic [3:0]      out_opcode_q, out_opcode_d;
    logic [XLEN-1:0] out_num1_q, out_num1_d;
    logic [XLEN-1:0] out_num2_q, out_num2_d;
    logic [4:0]      out_rd_q, out_rd_d;
    logic [4:0]      rs1_q, rs1_d;
    logic [4:0]      rs2_q, rs2_d;
    logic            use_imm_q, use_imm_d;

    logic accept;
    logic holding;

    assign in_ready = (!out_valid_q || out_ready) && !flush;
    assign accept   = in_valid && in_ready;
    // Entry stays in place this edge: operands must track writebacks to
    // its sources so the request never goes stale while stalled.
    assign holding  = out_valid_q && !out_ready && !flush;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_opcode_d = out_opcode_q;
        out_num1_d   = out_num1_q;
        out_num2_d   = out_num2_q;
        out_rd_d     = out_rd_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        use_imm_d    = use_imm_q;

        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d  = 1'b1;
            out_opcode_d = in_alu_op;
            out_rd_d     = in_rd;
            out_num1_d   = rd1_val;
            out_num2_d   = in_use_imm ? in_imm : rd2_val;
            rs1_d        = in_rs1;
            rs2_d        = in_rs2;
            use_imm_d    = in_use_imm;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (holding && wb_live) begin
            if (wb_rd == rs1_q)               out_num1_d = wb_data;
            if (!use_imm_q && wb_rd == rs2_q) out_num2_d = wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_q         <= '{default: '0};
            out_valid_q  <= 1'b0;
            out_opcode_q <= '0;
            out_num1_q   <= '0;
            out_num2_q   <= '0;
            out_rd_q     <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            use_imm_q    <= 1'b0;
        end else begin
            rf_q         <= rf_d;
            out_valid_q  <= out_valid_d;
            out_opcode_q <= out_opcode_d;
            out_num1_q   <= out_num1_d;
            out_num2_q   <= out_num2_d;
            out_rd_q     <= out_rd_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            use_imm_q    <= use_imm_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_opcode = out_opcode_q;
    assign out_num1   = out_num1_q;
    assign out_num2   = out_num2_q;
    assign out_rd     = out_rd_q;

endmodule

// File: tb/tb_operand_stage.sv
// Directed bench for operand_stage: each table row is one clock cycle of
// inputs, the expected in_ready before the edge, and the expected output
// entry after the edge.
module tb_operand_stage;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      in_alu_op;
    logic [4:0]      in_rs1, in_rs2, in_rd;
    logic            in_use_imm;
    logic [XLEN-1:0] in_imm;
    logic            wb_en;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      out_opcode;
    logic [XLEN-1:0] out_num1, out_num2;
    logic [4:0]      out_rd;

    operand_stage #(.XLEN(XLEN), .NREGS(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_op(in_alu_op), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_rd(in_rd), .in_use_imm(in_use_imm), .in_imm(in_imm),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_num1(out_num1),
        .out_num2(out_num2), .out_rd(out_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        iv;
        logic [3:0]  op;
        logic [4:0]  rs1, rs2, rd;
        logic        ui;
        logic [31:0] imm;
        logic        wbe;
        logic [4:0]  wbrd;
        logic [31:0] wbd;
        logic        fl;
        logic        ordy;
        logic        e_rdy;
        logic        e_v;
        logic        chk;
        logic [3:0]  e_op;
        logic [31:0] e_n1, e_n2;
        logic [4:0]  e_rd;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    function automatic vec_t mk(
        input logic rst_i, input logic iv, input logic [3:0] op,
        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
        input logic ui, input logic [31:0] imm,
        input logic wbe, input logic [4:0] wbrd, input logic [31:0] wbd,
        input logic fl, input logic ordy,
        input logic e_rdy, input logic e_v, input logic chk,
        input logic [3:0] e_op, input logic [31:0] e_n1, input logic [31:0] e_n2,
        input logic [4:0] e_rd);
        vec_t v;
        v.rst = rst_i; v.iv = iv; v.op = op; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
        v.ui = ui; v.imm = imm; v.wbe = wbe; v.wbrd = wbrd; v.wbd = wbd;
        v.fl = fl; v.ordy = ordy; v.e_rdy = e_rdy; v.e_v = e_v; v.chk = chk;
        v.e_op = e_op; v.e_n1 = e_n1; v.e_n2 = e_n2; v.e_rd = e_rd;
        return v;
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; in_valid = v.iv; in_alu_op = v.op;
        in_rs1 = v.rs1; in_rs2 = v.rs2; in_rd = v.rd;
        in_use_imm = v.ui; in_imm = v.imm;
        wb_en = v.wbe; wb_rd = v.wbrd; wb_data = v.wbd;
        flush = v.fl; out_ready = v.ordy;
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        drive(v);
        #1;
        check("in_ready", idx, 64'(in_ready), 64'(v.e_rdy));
        @(posedge clk);
        #1;
        n_vec++;
        check("out_valid", idx, 64'(out_valid), 64'(v.e_v));
        if (v.chk) begin
            check("out_opcode", idx, 64'(out_opcode), 64'(v.e_op));
            check("out_num1",   idx, 64'(out_num1),   64'(v.e_n1));
            check("out_num2",   idx, 64'(out_num2),   64'(v.e_n2));
            check("out_rd",     idx, 64'(out_rd),     64'(v.e_rd));
        end
    endtask

    vec_t tbl[$];

    initial begin
        //         rst iv op  rs1 rs2 rd ui imm           wbe wbrd wbd           fl ordy rdy v chk op  n1            n2            rd
        tbl.push_back(mk(1, 0, 0,  0,  0, 0, 0, 32'h0,        0, 0,  32'h0,        0, 1,   1, 0, 1, 0, 32'h0,        32'h0,        0));
        tbl.push_back(mk(0, 0, 0,  0,  0, 0, 0, 32'h0,        1, 5,  32'h10,       0, 1,   1, 0, 0, 0, 32'h0,        32'h0,        0));
        tbl.push_back(mk(0, 1, 0,  5,  0, 1, 0, 32'h0,        0, 0,  32'h0,        0, 1,   1, 1, 1, 0, 32'h10,       32'h0,        1));
        // same-cycle writeback bypass on rs1
        tbl.push_back(mk(0, 1, 2,  7,  5, 2, 0, 32'h0,        1, 7,  32'hDEADBEEF, 0, 1,   1, 1, 1, 2, 32'hDEADBEEF, 32'h10,       2));
        // write to x0 ignored, handoff without accept empties stage
        tbl.push_back(mk(0, 0, 0,  0,  0, 0, 0, 32'h0,        1, 0,  32'h5,        0, 1,   1, 0, 0, 0, 32'h0,        32'h0,        0));
        tbl.push_back(mk(0, 1, 3,  0,  0, 3, 1, 32'hFFFFFFF0, 0, 0,  32'h0,        0, 1,   1, 1, 1, 3, 32'h0,        32'hFFFFFFF0, 3));
        // hold with snooped writebacks
        tbl.push_back(mk(0, 1, 4,  5,  3, 4, 0, 32'h0,        0, 0,  32'h0,        0, 1,   1, 1, 1, 4, 32'h10,       32'h0,        4));
        tbl.push_back(mk(0, 1, 9,  1,  1, 9, 0, 32'h0,        0, 0,  32'h0,        0, 0,   0, 1, 1, 4, 32'h10,       32'h0,        4));
        tbl.push_back(mk(0, 1, 9,  1,  1, 9, 0, 32'h0,        1, 3,  32'h55,       0, 0,   0, 1, 1, 4, 32'h10,       32'h55,       4));
        tbl.push_back(mk(0, 0, 9,  1,  1, 9, 0, 32'h0,        1, 5,  32'h77,       0, 0,   0, 1, 1, 4, 32'h77,       32'h55,       4));
        tbl.push_back(mk(0, 0, 0,  0,  0, 0, 0, 32'h0,        0, 0,  32'h0,        0, 1,   1, 0, 0, 0, 32'h0,        32'h0,        0));
        // held immediate entry ignores writeback to rs2
        tbl.push_back(mk(0, 1, 5,  0,  3, 5, 1, 32'h100,      0, 0,  32'h0,        0, 0,   1, 1, 1, 5, 32'h0,        32'h100,      5));
        tbl.push_back(mk(0, 0, 0,  0,  0, 0, 0, 32'h0,        1, 3,  32'h99,       0, 0,   0, 1, 1, 5, 32'h0,        32'h100,      5));
        // flush over held entry; regfile write still lands
        tbl.push_back(mk(0, 1, 6,  1,  1, 6, 0, 32'h0,        1, 10, 32'hABC,      1, 0,   0, 0, 0, 0, 32'h0,        32'h0,        0));
        tbl.push_back(mk(0, 1, 7, 10,  3, 6, 0, 32'h0,        0, 0,  32'h0,        0, 1,   1, 1, 1, 7, 32'hABC,      32'h99,       6));
        tbl.push_back(mk(0, 1, 8,  1,  1, 7, 0, 32'h0,        0, 0,  32'h0,        1, 1,   0, 0, 0, 0, 32'h0,        32'h0,        0));
        // reset mid-operation wipes registers and the held entry
        tbl.push_back(mk(0, 1, 8,  9,  9, 7, 0, 32'h0,        1, 9,  32'h1234,     0, 1,   1, 1, 1, 8, 32'h1234,     32'h1234,     7));
        tbl.push_back(mk(1, 1, 2,  1,  1, 2, 0, 32'h0,        1, 11, 32'h5,        1, 0,   0, 0, 1, 0, 32'h0,        32'h0,        0));
        tbl.push_back(mk(0, 1, 1,  9, 11, 8, 0, 32'h0,        0, 0,  32'h0,        0, 1,   1, 1, 1, 1, 32'h0,        32'h0,        8));

        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // Back-to-back stream: one instruction per cycle, no bubbles.
        for (int i = 0; i < 8; i++) begin
            apply(mk(0, 1, 4'(i), 0, 0, 5'(i + 1), 1, 32'h1000 + 32'(i),
                     0, 0, 0, 0, 1,
                     1, 1, 1, 4'(i), 32'h0, 32'h1000 + 32'(i), 5'(i + 1)), 100 + i);
        end
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0), 108);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
